// File: rtl/reg_stacks_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_stacks_if
// Description : Operand-fetch / write-back bus of the per-thread register
//               stacks (read selects, pops, push data, error pulses).
// Revision    : 1.0
// ============================================================================
interface reg_stacks_if #(
    parameter int THRD_W = 3,
    parameter int STK_W  = 2,
    parameter int DATA_W = 32
);
    localparam int c_STACKS = 1 << STK_W;

    logic [THRD_W-1:0]   thrd_rd_i;
    logic [STK_W-1:0]    sel_a_i;
    logic [STK_W-1:0]    sel_b_i;
    logic                pop_a_i;
    logic                pop_b_i;
    logic [DATA_W-1:0]   a_o;
    logic [DATA_W-1:0]   b_o;
    logic [THRD_W-1:0]   thrd_wr_i;
    logic [STK_W-1:0]    sel_wr_i;
    logic                push_i;
    logic [DATA_W-1:0]   wr_data_i;
    logic [c_STACKS-1:0] pop_er_o;
    logic [c_STACKS-1:0] push_er_o;

    modport master (
        output thrd_rd_i, sel_a_i, sel_b_i, pop_a_i, pop_b_i,
        output thrd_wr_i, sel_wr_i, push_i, wr_data_i,
        input  a_o, b_o, pop_er_o, push_er_o
    );

    modport slave (
        input  thrd_rd_i, sel_a_i, sel_b_i, pop_a_i, pop_b_i,
        input  thrd_wr_i, sel_wr_i, push_i, wr_data_i,
        output a_o, b_o, pop_er_o, push_er_o
    );
endinterface
`default_nettype wire

// File: rtl/reg_stacks.sv
`default_nettype none
// ============================================================================
// Module      : reg_stacks
// Description : Per-thread hardware operand stacks, one RAM per stack, with
//               registered top-of-stack reads and under/overflow pulses.
//               Optional macro STK_PROT_EN saturates levels instead of wrapping.
// Revision    : 1.0
// ============================================================================
module reg_stacks #(
    parameter int THRD_W = 3,
    parameter int STK_W  = 2,
    parameter int PTR_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    reg_stacks_if.slave bus
);
    localparam int c_THREADS = 1 << THRD_W;
    localparam int c_STACKS  = 1 << STK_W;
    localparam int c_DEPTH   = 1 << PTR_W;
    localparam int c_CNT     = c_THREADS * c_STACKS;
    localparam int c_RAM_D   = c_DEPTH * c_THREADS;
    localparam int c_LVL_W   = PTR_W + 1;

    localparam logic [c_LVL_W-1:0] c_LVL_ONE  = c_LVL_W'(1);
    localparam logic [c_LVL_W-1:0] c_LVL_TOP  = c_LVL_W'(c_DEPTH - 1);
    localparam logic [c_LVL_W-1:0] c_LVL_FULL = c_LVL_W'(c_DEPTH);

    logic [THRD_W-1:0]   w_thrd_rd;
    logic [STK_W-1:0]    w_sel_a;
    logic [STK_W-1:0]    w_sel_b;
    logic                w_pop_a;
    logic                w_pop_b;
    logic [THRD_W-1:0]   w_thrd_wr;
    logic [STK_W-1:0]    w_sel_wr;
    logic                w_push;
    logic [DATA_W-1:0]   w_wr_data;

    assign w_thrd_rd = bus.thrd_rd_i;
    assign w_sel_a   = bus.sel_a_i;
    assign w_sel_b   = bus.sel_b_i;
    assign w_pop_a   = bus.pop_a_i;
    assign w_pop_b   = bus.pop_b_i;
    assign w_thrd_wr = bus.thrd_wr_i;
    assign w_sel_wr  = bus.sel_wr_i;
    assign w_push    = bus.push_i;
    assign w_wr_data = bus.wr_data_i;

    logic [c_LVL_W-1:0]  lvl_q [c_CNT];
    logic [c_LVL_W-1:0]  lvl_d [c_CNT];
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   a_d;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   b_d;
    logic [c_STACKS-1:0] pop_er_q;
    logic [c_STACKS-1:0] pop_er_d;
    logic [c_STACKS-1:0] push_er_q;
    logic [c_STACKS-1:0] push_er_d;

    logic [c_STACKS-1:0] w_pop_msk;
    logic [c_CNT-1:0]    w_cnt_pop;
    logic [c_CNT-1:0]    w_cnt_push;
    logic [PTR_W-1:0]    w_rd_idx  [c_STACKS];
    logic [DATA_W-1:0]   w_rd_data [c_STACKS];
    logic [c_LVL_W-1:0]  w_wr_lvl;
    logic                w_wr_same;
    logic                w_wr_en;
    logic                w_wr_go;
    logic [PTR_W-1:0]    w_wr_idx;
    logic                w_ovf;

    // Both read ports popping the same stack collapse into a single pop.
    always_comb begin
        w_pop_msk = '0;
        if (w_pop_a) w_pop_msk[w_sel_a] = 1'b1;
        if (w_pop_b) w_pop_msk[w_sel_b] = 1'b1;
    end

    // Read side: each stack exposes the entry just below its level for the
    // reading thread; level 0 wraps to index DEPTH-1.
    always_comb begin
        pop_er_d = '0;
        for (int s = 0; s < c_STACKS; s++) begin
            w_rd_idx[s] = PTR_W'(lvl_q[{w_thrd_rd, STK_W'(s)}] - c_LVL_ONE);
            pop_er_d[s] = w_pop_msk[s] && (lvl_q[{w_thrd_rd, STK_W'(s)}] == '0);
        end
    end

    assign a_d = w_rd_data[w_sel_a];
    assign b_d = w_rd_data[w_sel_b];

    // Write side: a push that meets a pop on the same pair replaces the
    // popped slot, so it never overflows.
    assign w_wr_lvl  = lvl_q[{w_thrd_wr, w_sel_wr}];
    assign w_wr_same = (w_thrd_rd == w_thrd_wr) && w_pop_msk[w_sel_wr];

    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_idx = PTR_W'(w_wr_lvl);
        w_ovf    = 1'b0;
        if (w_push) begin
            w_wr_en = 1'b1;
            if (w_wr_same) begin
`ifdef STK_PROT_EN
                if (w_wr_lvl != '0) w_wr_idx = PTR_W'(w_wr_lvl - c_LVL_ONE);
`else
                w_wr_idx = PTR_W'(w_wr_lvl - c_LVL_ONE);
`endif
            end else if (w_wr_lvl == c_LVL_FULL) begin
                w_ovf = 1'b1;
`ifdef STK_PROT_EN
                w_wr_en = 1'b0;
`endif
            end
        end
    end

    always_comb begin
        push_er_d = '0;
        if (w_ovf) push_er_d[w_sel_wr] = 1'b1;
    end

    assign w_wr_go = w_wr_en && !rst_i;

    always_comb begin
        for (int k = 0; k < c_CNT; k++) begin
            w_cnt_pop[k]  = (w_thrd_rd == THRD_W'(k >> STK_W)) && w_pop_msk[STK_W'(k)];
            w_cnt_push[k] = w_push && (w_thrd_wr == THRD_W'(k >> STK_W))
                            && (w_sel_wr == STK_W'(k));
            lvl_d[k] = lvl_q[k];
            if (w_cnt_pop[k] && w_cnt_push[k]) begin
`ifdef STK_PROT_EN
                if (lvl_q[k] == '0) lvl_d[k] = c_LVL_ONE;
`endif
            end else if (w_cnt_pop[k]) begin
                if (lvl_q[k] == '0) begin
`ifdef STK_PROT_EN
                    lvl_d[k] = '0;
`else
                    lvl_d[k] = c_LVL_TOP;
`endif
                end else begin
                    lvl_d[k] = lvl_q[k] - c_LVL_ONE;
                end
            end else if (w_cnt_push[k]) begin
                if (lvl_q[k] == c_LVL_FULL) begin
`ifdef STK_PROT_EN
                    lvl_d[k] = c_LVL_FULL;
`else
                    lvl_d[k] = c_LVL_ONE;
`endif
                end else begin
                    lvl_d[k] = lvl_q[k] + c_LVL_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < c_CNT; k++) lvl_q[k] <= '0;
            a_q       <= '0;
            b_q       <= '0;
            pop_er_q  <= '0;
            push_er_q <= '0;
        end else begin
            for (int k = 0; k < c_CNT; k++) lvl_q[k] <= lvl_d[k];
            a_q       <= a_d;
            b_q       <= b_d;
            pop_er_q  <= pop_er_d;
            push_er_q <= push_er_d;
        end
    end

    // One RAM per stack, {thread, index} addressed, contents never cleared.
    for (genvar s = 0; s < c_STACKS; s++) begin : g_ram
        logic [DATA_W-1:0] mem_q [c_RAM_D];

        always_ff @(posedge clk_i) begin
            if (w_wr_go && (w_sel_wr == STK_W'(s)))
                mem_q[{w_thrd_wr, w_wr_idx}] <= w_wr_data;
        end

        assign w_rd_data[s] = mem_q[{w_thrd_rd, w_rd_idx[s]}];
    end

    assign bus.a_o       = a_q;
    assign bus.b_o       = b_q;
    assign bus.pop_er_o  = pop_er_q;
    assign bus.push_er_o = push_er_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_stacks.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_stacks
// Description : Directed table-driven bench for reg_stacks (default build or
//               STK_PROT_EN build).
// Revision    : 1.0
// ============================================================================
module tb_reg_stacks;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    reg_stacks_if #(.THRD_W(3), .STK_W(2), .DATA_W(32)) bus ();

    reg_stacks #(.THRD_W(3), .STK_W(2), .PTR_W(5), .DATA_W(32)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]  trd;
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic        pa;
        logic        pb;
        logic [2:0]  twr;
        logic [1:0]  swr;
        logic        psh;
        logic [31:0] wd;
        logic        ck;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [3:0]  epe;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic [2:0] trd, input logic [1:0] sa,
                                input logic [1:0] sb, input logic pa, input logic pb,
                                input logic [2:0] twr, input logic [1:0] swr,
                                input logic psh, input logic [31:0] wd, input logic ck,
                                input logic [31:0] ea, input logic [31:0] eb,
                                input logic [3:0] epe);
        vec_t v;
        v.trd = trd; v.sa = sa; v.sb = sb; v.pa = pa; v.pb = pb;
        v.twr = twr; v.swr = swr; v.psh = psh; v.wd = wd;
        v.ck = ck; v.ea = ea; v.eb = eb; v.epe = epe;
        return v;
    endfunction

    function automatic vec_t pu(input logic [2:0] t, input logic [1:0] s, input logic [31:0] d);
        return mk(3'd0, 2'd0, 2'd0, 1'b0, 1'b0, t, s, 1'b1, d, 1'b0, 32'd0, 32'd0, 4'd0);
    endfunction

    function automatic vec_t rd(input logic [2:0] t, input logic [1:0] sa, input logic [1:0] sb,
                                input logic pa, input logic pb, input logic ck,
                                input logic [31:0] ea, input logic [31:0] eb, input logic [3:0] epe);
        return mk(t, sa, sb, pa, pb, 3'd0, 2'd0, 1'b0, 32'd0, ck, ea, eb, epe);
    endfunction

    task automatic drive(input vec_t v);
        bus.thrd_rd_i = v.trd;
        bus.sel_a_i   = v.sa;
        bus.sel_b_i   = v.sb;
        bus.pop_a_i   = v.pa;
        bus.pop_b_i   = v.pb;
        bus.thrd_wr_i = v.twr;
        bus.sel_wr_i  = v.swr;
        bus.push_i    = v.psh;
        bus.wr_data_i = v.wd;
    endtask

    task automatic idle();
        drive(rd(3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0));
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    initial begin
        idle();
        #1 rst_i = 1'b1;
        repeat (3) step();
        chk("rst_a", bus.a_o, 32'd0);
        chk("rst_b", bus.b_o, 32'd0);
        chk("rst_pop_er", 32'(bus.pop_er_o), 32'd0);
        chk("rst_push_er", 32'(bus.push_er_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        tv.push_back(pu(3'd2, 2'd1, 32'h11111111));
        tv.push_back(pu(3'd2, 2'd1, 32'h22222222));
        tv.push_back(rd(3'd2, 2'd1, 2'd1, 1'b1, 1'b0, 1'b1, 32'h22222222, 32'h22222222, 4'b0000));
        tv.push_back(rd(3'd2, 2'd1, 2'd1, 1'b1, 1'b0, 1'b1, 32'h11111111, 32'h11111111, 4'b0000));
        tv.push_back(rd(3'd2, 2'd1, 2'd1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'b0010));
        tv.push_back(pu(3'd3, 2'd2, 32'hAAAA0001));
        tv.push_back(pu(3'd3, 2'd2, 32'hAAAA0002));
        tv.push_back(rd(3'd3, 2'd2, 2'd2, 1'b1, 1'b1, 1'b1, 32'hAAAA0002, 32'hAAAA0002, 4'b0000));
        tv.push_back(rd(3'd3, 2'd2, 2'd2, 1'b1, 1'b0, 1'b1, 32'hAAAA0001, 32'hAAAA0001, 4'b0000));
        tv.push_back(rd(3'd3, 2'd2, 2'd2, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'b0100));
        tv.push_back(pu(3'd4, 2'd0, 32'h000000C0));
        tv.push_back(pu(3'd1, 2'd0, 32'h00000010));
        tv.push_back(mk(3'd4, 2'd0, 2'd0, 1'b0, 1'b0, 3'd1, 2'd0, 1'b1, 32'h00000011,
                        1'b1, 32'h000000C0, 32'h000000C0, 4'b0000));
        tv.push_back(mk(3'd1, 2'd0, 2'd0, 1'b1, 1'b0, 3'd4, 2'd0, 1'b1, 32'h000000C1,
                        1'b1, 32'h00000011, 32'h00000011, 4'b0000));
        tv.push_back(rd(3'd4, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 32'h000000C1, 32'h000000C1, 4'b0000));
        tv.push_back(rd(3'd1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 32'h00000010, 32'h00000010, 4'b0000));
        tv.push_back(rd(3'd4, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 32'h000000C0, 32'h000000C0, 4'b0000));
        tv.push_back(rd(3'd4, 2'd0, 2'd3, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 4'b1001));
        tv.push_back(rd(3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'b0000));
        tv.push_back(pu(3'd6, 2'd1, 32'h00000001));
        tv.push_back(pu(3'd6, 2'd1, 32'h00000002));
        tv.push_back(pu(3'd6, 2'd1, 32'h0000000A));
        tv.push_back(mk(3'd6, 2'd1, 2'd1, 1'b1, 1'b0, 3'd6, 2'd1, 1'b1, 32'h0000000B,
                        1'b1, 32'h0000000A, 32'h0000000A, 4'b0000));
        tv.push_back(rd(3'd6, 2'd1, 2'd1, 1'b0, 1'b0, 1'b1, 32'h0000000B, 32'h0000000B, 4'b0000));
        tv.push_back(rd(3'd6, 2'd1, 2'd1, 1'b1, 1'b0, 1'b1, 32'h0000000B, 32'h0000000B, 4'b0000));
        tv.push_back(rd(3'd6, 2'd1, 2'd1, 1'b1, 1'b0, 1'b1, 32'h00000002, 32'h00000002, 4'b0000));
        tv.push_back(rd(3'd6, 2'd1, 2'd1, 1'b1, 1'b0, 1'b1, 32'h00000001, 32'h00000001, 4'b0000));
        tv.push_back(rd(3'd6, 2'd1, 2'd1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'b0010));
        tv.push_back(rd(3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'b0000));

        foreach (tv[i]) begin
            drive(tv[i]);
            step();
            if (tv[i].ck) begin
                chk($sformatf("v%0d_a", i), bus.a_o, tv[i].ea);
                chk($sformatf("v%0d_b", i), bus.b_o, tv[i].eb);
            end
            chk($sformatf("v%0d_pop_er", i), 32'(bus.pop_er_o), 32'(tv[i].epe));
            chk($sformatf("v%0d_push_er", i), 32'(bus.push_er_o), 32'd0);
        end

        // Underflow on an empty stack, then the resulting level seen by pushes.
        drive(rd(3'd0, 2'd3, 2'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0));
        step();
        chk("s2_pop_er", 32'(bus.pop_er_o), 32'h8);
        idle();
        step();
        chk("s2_pop_er_clr", 32'(bus.pop_er_o), 32'h0);
        drive(pu(3'd0, 2'd3, 32'h0000000D));
        step();
        chk("s2_push1_er", 32'(bus.push_er_o), 32'h0);
        drive(rd(3'd0, 2'd3, 2'd3, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0));
        step();
        chk("s2_read", bus.a_o, 32'h0000000D);
        drive(pu(3'd0, 2'd3, 32'h0000000E));
        step();
`ifdef STK_PROT_EN
        chk("s2_push2_er", 32'(bus.push_er_o), 32'h0);
`else
        chk("s2_push2_er", 32'(bus.push_er_o), 32'h8);
`endif

        // Fill thread 5 stack 0 past its depth.
        for (int i = 0; i < 33; i++) begin
            drive(pu(3'd5, 2'd0, 32'(i)));
            step();
            chk($sformatf("s3_push_er_%0d", i), 32'(bus.push_er_o), (i == 32) ? 32'h1 : 32'h0);
        end
        idle();
        step();
        chk("s3_push_er_clr", 32'(bus.push_er_o), 32'h0);
        drive(rd(3'd5, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0));
        step();
`ifdef STK_PROT_EN
        chk("s3_pop_top", bus.a_o, 32'd31);
`else
        chk("s3_pop_top", bus.a_o, 32'd32);
`endif

        // Burst of pushes interrupted by an asynchronous reset.
        drive(pu(3'd0, 2'd0, 32'h00000100)); step();
        drive(pu(3'd7, 2'd1, 32'h00000101)); step();
        drive(pu(3'd1, 2'd2, 32'h00000102)); step();
        drive(pu(3'd5, 2'd3, 32'h00000103)); step();
        drive(mk(3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 3'd3, 2'd1, 1'b1, 32'h000001FF,
                 1'b0, 32'd0, 32'd0, 4'd0));
        step();
        chk("s6_pre_a", bus.a_o, 32'h00000100);
        drive(mk(3'd7, 2'd1, 2'd0, 1'b1, 1'b0, 3'd6, 2'd2, 1'b1, 32'h00000200,
                 1'b0, 32'd0, 32'd0, 4'd0));
        #2 rst_i = 1'b1;
        #1;
        chk("s6_rst_a", bus.a_o, 32'd0);
        chk("s6_rst_b", bus.b_o, 32'd0);
        chk("s6_rst_pop_er", 32'(bus.pop_er_o), 32'd0);
        chk("s6_rst_push_er", 32'(bus.push_er_o), 32'd0);
        step();
        step();
        idle();
        @(negedge clk_i);
        rst_i = 1'b0;
        drive(rd(3'd7, 2'd1, 2'd1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0));
        step();
        chk("s6_post_pop_er", 32'(bus.pop_er_o), 32'h2);
        drive(rd(3'd6, 2'd2, 2'd2, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0));
        step();
        chk("s6_discard_pop_er", 32'(bus.pop_er_o), 32'h4);
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
`default_nettype wire
